// File: rtl/spi_uart_router.sv
// Multi-channel router: SPI downstream words fan out into per-channel UART TX FIFOs,
// and UART RX words are merged round-robin into one tagged upstream register.
module spi_uart_router #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     down_valid,
    output logic                     down_ready,
    input  logic [DATA_W-1:0]        down_data,
    input  logic [CH_W-1:0]          down_ch,
    output logic [NUM_CH-1:0]        ch_tx_valid,
    input  logic [NUM_CH-1:0]        ch_tx_ready,
    output logic [NUM_CH*DATA_W-1:0] ch_tx_data,
    input  logic [NUM_CH-1:0]        ch_rx_valid,
    output logic [NUM_CH-1:0]        ch_rx_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_rx_data,
    output logic                     up_valid,
    input  logic                     up_ready,
    output logic [DATA_W-1:0]        up_data,
    output logic [CH_W-1:0]          up_ch,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     drop_mode,
    input  logic                     drop_clr,
    output logic [NUM_CH*8-1:0]      drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wrPtr_q [NUM_CH];
    logic [PW-1:0]     rdPtr_q [NUM_CH];
    logic [DATA_W-1:0] mem_q   [NUM_CH][DEPTH];
    logic [7:0]        dropCnt_q [NUM_CH];

    logic              upValid_q, upValid_d;
    logic [DATA_W-1:0] upData_q, upData_d;
    logic [CH_W-1:0]   upCh_q, upCh_d;
    logic [CH_W-1:0]   lastGrant_q, lastGrant_d;

    logic [NUM_CH-1:0] full, empty, push, pop, drop, chHit;
    logic              chInRange, selFull, selEn, downFire;
    logic              loadable, grantFound;
    logic [CH_W-1:0]   grantIdx, cand;
    logic [DATA_W-1:0] grantData;

    always_comb begin
        ch_tx_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i] = (wrPtr_q[i] == rdPtr_q[i]);
            full[i]  = ((wrPtr_q[i] ^ rdPtr_q[i]) == PW'(DEPTH));
            ch_tx_data[i*DATA_W +: DATA_W] = mem_q[i][rdPtr_q[i][AW-1:0]];
        end
    end

    assign ch_tx_valid = ~empty;

    // Backpressure only ever applies to an enabled, in-range, full channel; everything else is swallowed.
    always_comb begin
        chInRange = ({1'b0, down_ch} < (CH_W+1)'(NUM_CH));
        selFull   = 1'b0;
        selEn     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (down_ch == CH_W'(i)) begin
                selFull = full[i];
                selEn   = ch_enable[i];
            end
        end
        if (drop_mode)
            down_ready = 1'b1;
        else if (chInRange && selEn)
            down_ready = !selFull;
        else
            down_ready = 1'b1;
        downFire = down_valid && down_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            chHit[i] = downFire && chInRange && (down_ch == CH_W'(i));
            push[i]  = chHit[i] && ch_enable[i] && !full[i];
            drop[i]  = chHit[i] && (!ch_enable[i] || full[i]);
            pop[i]   = ch_tx_ready[i] && !empty[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
                if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem_q[i][wrPtr_q[i][AW-1:0]] <= down_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) dropCnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (drop_clr)
                    dropCnt_q[i] <= '0;
                else if (drop[i] && (dropCnt_q[i] != 8'hFF))
                    dropCnt_q[i] <= dropCnt_q[i] + 8'd1;
            end
        end
    end

    // Round-robin search starts one past the last grant so every requester is served in turn.
    always_comb begin
        loadable   = !rst && (!upValid_q || up_ready);
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(lastGrant_q) + k) % NUM_CH);
            if (!grantFound && ch_rx_valid[cand] && ch_enable[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
        ch_rx_ready = '0;
        if (loadable && grantFound) ch_rx_ready[grantIdx] = 1'b1;
        grantData = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grantIdx == CH_W'(i)) grantData = ch_rx_data[i*DATA_W +: DATA_W];
        end
        upValid_d   = upValid_q;
        upData_d    = upData_q;
        upCh_d      = upCh_q;
        lastGrant_d = lastGrant_q;
        if (loadable) begin
            if (grantFound) begin
                upValid_d   = 1'b1;
                upData_d    = grantData;
                upCh_d      = grantIdx;
                lastGrant_d = grantIdx;
            end else begin
                upValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upValid_q   <= 1'b0;
            upData_q    <= '0;
            upCh_q      <= '0;
            lastGrant_q <= CH_W'(NUM_CH - 1);
        end else begin
            upValid_q   <= upValid_d;
            upData_q    <= upData_d;
            upCh_q      <= upCh_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign up_valid = upValid_q;
    assign up_data  = upData_q;
    assign up_ch    = upCh_q;

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) drop_cnt[i*8 +: 8] = dropCnt_q[i];
    end

endmodule

// File: tb/tb_spi_uart_router.sv
// Bench for spi_uart_router: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the router's rules.
module tb_spi_uart_router;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     down_valid;
    logic                     down_ready;
    logic [DATA_W-1:0]        down_data;
    logic [CH_W-1:0]          down_ch;
    logic [NUM_CH-1:0]        ch_tx_valid;
    logic [NUM_CH-1:0]        ch_tx_ready;
    logic [NUM_CH*DATA_W-1:0] ch_tx_data;
    logic [NUM_CH-1:0]        ch_rx_valid;
    logic [NUM_CH-1:0]        ch_rx_ready;
    logic [NUM_CH*DATA_W-1:0] ch_rx_data;
    logic                     up_valid;
    logic                     up_ready;
    logic [DATA_W-1:0]        up_data;
    logic [CH_W-1:0]          up_ch;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     drop_mode;
    logic                     drop_clr;
    logic [NUM_CH*8-1:0]      drop_cnt;

    always #5 clk = ~clk;

    spi_uart_router #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data), .down_ch(down_ch),
        .ch_tx_valid(ch_tx_valid), .ch_tx_ready(ch_tx_ready), .ch_tx_data(ch_tx_data),
        .ch_rx_valid(ch_rx_valid), .ch_rx_ready(ch_rx_ready), .ch_rx_data(ch_rx_data),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ch(up_ch),
        .ch_enable(ch_enable), .drop_mode(drop_mode), .drop_clr(drop_clr), .drop_cnt(drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] modelQ [NUM_CH][$];
    int                modelCnt [NUM_CH];
    logic              modelUpValid;
    logic [DATA_W-1:0] modelUpData;
    int                modelUpCh;
    int                modelLast;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic expDownReady();
        if (drop_mode) return 1'b1;
        if (int'(down_ch) < NUM_CH && ch_enable[down_ch]) return modelQ[down_ch].size() < DEPTH;
        return 1'b1;
    endfunction

    function automatic int expGrant();
        int idx;
        if (rst) return -1;
        if (modelUpValid && !up_ready) return -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (modelLast + k) % NUM_CH;
            if (ch_rx_valid[idx] && ch_enable[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            modelQ[i].delete();
            modelCnt[i] = 0;
        end
        modelUpValid = 1'b0;
        modelUpData  = '0;
        modelUpCh    = 0;
        modelLast    = NUM_CH - 1;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic modelStep();
        int g, pushCh, dropCh;
        logic fire;
        if (rst) begin
            modelReset();
            return;
        end
        g = expGrant();
        pushCh = -1;
        dropCh = -1;
        fire = down_valid && expDownReady();
        if (fire && int'(down_ch) < NUM_CH) begin
            if (ch_enable[down_ch] && modelQ[down_ch].size() < DEPTH) pushCh = int'(down_ch);
            else dropCh = int'(down_ch);
        end
        for (int i = 0; i < NUM_CH; i++)
            if (ch_tx_ready[i] && modelQ[i].size() > 0) void'(modelQ[i].pop_front());
        if (pushCh >= 0) modelQ[pushCh].push_back(down_data);
        for (int i = 0; i < NUM_CH; i++) begin
            if (drop_clr) modelCnt[i] = 0;
            else if (i == dropCh && modelCnt[i] < 255) modelCnt[i]++;
        end
        if (!modelUpValid || up_ready) begin
            if (g >= 0) begin
                modelUpValid = 1'b1;
                modelUpData  = ch_rx_data[g*DATA_W +: DATA_W];
                modelUpCh    = g;
                modelLast    = g;
            end else begin
                modelUpValid = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        int g;
        g = expGrant();
        compare("down_ready", down_ready, expDownReady());
        compare("ch_rx_ready", ch_rx_ready, (g < 0) ? 0 : (1 << g));
        for (int i = 0; i < NUM_CH; i++) begin
            compare($sformatf("ch_tx_valid[%0d]", i), ch_tx_valid[i], modelQ[i].size() > 0);
            if (modelQ[i].size() > 0)
                compare($sformatf("ch_tx_data[%0d]", i), ch_tx_data[i*DATA_W +: DATA_W], modelQ[i][0]);
            compare($sformatf("drop_cnt[%0d]", i), drop_cnt[i*8 +: 8], modelCnt[i]);
        end
        compare("up_valid", up_valid, modelUpValid);
        compare("up_data", up_data, modelUpData);
        compare("up_ch", up_ch, modelUpCh);
    endtask

    // Inputs are set just after a falling edge; check and model update happen before the rising edge.
    task automatic applyStimulus();
        #2;
        checkOutput();
        modelStep();
        @(negedge clk);
    endtask

    task automatic idle();
        rst         = 1'b0;
        down_valid  = 1'b0;
        down_data   = '0;
        down_ch     = '0;
        ch_tx_ready = '0;
        ch_rx_valid = '0;
        ch_rx_data  = '0;
        up_ready    = 1'b0;
        ch_enable   = '1;
        drop_mode   = 1'b0;
        drop_clr    = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        modelReset();
        applyStimulus();
        compare("reset up_valid", up_valid, 0);
        compare("reset ch_tx_valid", ch_tx_valid, 0);
        compare("reset drop_cnt", drop_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            down_valid = 1'b1;
            down_ch    = CH_W'(i);
            down_data  = 16'(16'hA000 + i);
            applyStimulus();
            if (i == 0) compare("route first valid", ch_tx_valid, 4'b0001);
        end
        down_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            compare("route data", ch_tx_data[i*DATA_W +: DATA_W], 16'(16'hA000 + i));
        ch_tx_ready = '1;
        applyStimulus();
        ch_tx_ready = '0;

        for (int k = 0; k < 9; k++) begin
            down_valid = 1'b1;
            down_ch    = 2'd2;
            down_data  = 16'(16'hB000 + k);
            if (k == 8) begin
                #1;
                compare("bp ninth stalled", down_ready, 0);
            end
            applyStimulus();
        end
        ch_tx_ready[2] = 1'b1;
        applyStimulus();
        ch_tx_ready = '0;
        #1;
        compare("bp ninth after pop", down_ready, 1);
        applyStimulus();
        down_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            compare("bp drain order", ch_tx_data[2*DATA_W +: DATA_W], 16'(16'hB001 + k));
            ch_tx_ready[2] = 1'b1;
            applyStimulus();
        end
        ch_tx_ready = '0;
        compare("bp drained", ch_tx_valid[2], 0);

        drop_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            down_valid = 1'b1;
            down_ch    = 2'd2;
            down_data  = 16'(16'hC000 + k);
            #1;
            compare("drop mode ready", down_ready, 1);
            applyStimulus();
        end
        compare("drop count 4", drop_cnt[2*8 +: 8], 4);
        repeat (300) applyStimulus();
        compare("drop saturate", drop_cnt[2*8 +: 8], 255);
        down_valid = 1'b0;
        drop_clr   = 1'b1;
        applyStimulus();
        drop_clr = 1'b0;
        compare("drop clear", drop_cnt[2*8 +: 8], 0);
        ch_tx_ready[2] = 1'b1;
        repeat (8) applyStimulus();
        ch_tx_ready = '0;
        drop_mode   = 1'b0;

        for (int k = 0; k < 3; k++) begin
            down_valid = 1'b1;
            down_ch    = 2'd1;
            down_data  = 16'(16'hD100 + k);
            applyStimulus();
        end
        down_valid     = 1'b0;
        ch_enable[1]   = 1'b0;
        ch_rx_valid[1] = 1'b1;
        up_ready       = 1'b1;
        ch_tx_ready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            compare("disable drain", ch_tx_data[1*DATA_W +: DATA_W], 16'(16'hD100 + k));
            #1;
            compare("disable no grant", ch_rx_ready, 0);
            applyStimulus();
        end
        ch_tx_ready = '0;
        down_valid  = 1'b1;
        down_ch     = 2'd1;
        down_data   = 16'hD1FF;
        applyStimulus();
        down_valid = 1'b0;
        compare("disable drop count", drop_cnt[1*8 +: 8], 1);
        compare("disable not queued", ch_tx_valid[1], 0);
        ch_rx_valid = '0;
        ch_enable   = '1;

        for (int i = 0; i < NUM_CH; i++) ch_rx_data[i*DATA_W +: DATA_W] = 16'(16'hE000 + i);
        ch_rx_valid = '1;
        up_ready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            compare("arb grant", ch_rx_ready, 1 << (k % 4));
            applyStimulus();
            compare("arb up_ch", up_ch, k % 4);
            compare("arb up_data", up_data, 16'(16'hE000 + k % 4));
        end
        up_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            compare("stall no grant", ch_rx_ready, 0);
            applyStimulus();
            compare("stall hold", up_data, 16'hE003);
        end

        up_ready = 1'b1;
        applyStimulus();
        up_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            down_valid = 1'b1;
            down_ch    = (k % 2 == 0) ? 2'd0 : 2'd3;
            down_data  = 16'(16'hF000 + k);
            applyStimulus();
        end
        down_valid = 1'b0;
        rst = 1'b1;
        #1;
        compare("rst rx_ready", ch_rx_ready, 0);
        applyStimulus();
        rst = 1'b0;
        compare("rst up_valid", up_valid, 0);
        compare("rst fifos empty", ch_tx_valid, 0);
        compare("rst counters", drop_cnt, 0);
        up_ready = 1'b1;
        #1;
        compare("rst first grant", ch_rx_ready, 4'b0001);
        applyStimulus();
        idle();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = ($urandom_range(0, 299) == 0);
            down_valid = ($urandom_range(0, 3) != 0);
            down_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            down_data  = 16'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_enable[i]   = ($urandom_range(0, 7) != 0);
                ch_tx_ready[i] = ((cyc / 256) % 2 == 0) ? ($urandom_range(0, 9) == 0)
                                                        : ($urandom_range(0, 9) < 6);
                ch_rx_valid[i] = ($urandom_range(0, 1) == 1);
            end
            ch_rx_data = {$urandom, $urandom};
            up_ready   = ($urandom_range(0, 2) != 0);
            drop_clr   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) drop_mode = ~drop_mode;
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
